lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Round-robin controller that shares one `lifo` stack instance among NREQ independent requesters. Each requester issues push or pop requests with a valid/grant handshake. The arbiter selects at most one eligible requester per cycle and drives the stack's push/pop/data_in ports. It tracks stack occupancy internally and routes popped words back to the requester that issued the pop. It sits between the client blocks and the `lifo`, and is the only driver of the stack's control inputs.

## Interface
- WIDTH, 16, data word width (must match the `lifo` instance)
- DEPTH, 4, stack capacity in words (must match the `lifo` instance)
- NREQ, 4, number of requesters (2..8)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- req_push  input  NREQ  push request per requester; held until granted
- req_pop  input  NREQ  pop request per requester; held until granted
- req_data  input  NREQ*WIDTH  push data; slice i belongs to requester i
- gnt  output  NREQ  one-hot, combinational; gnt[i]=1 means requester i's operation is accepted this cycle
- rsp_valid  output  NREQ  one-hot registered; popped word available for requester i
- rsp_data  output  WIDTH  popped word, valid while any rsp_valid bit is set
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- err  output  1  sticky flag for an occupancy/flag mismatch
- lifo_push, lifo_pop  output  1  to the `lifo` push/pop ports
- lifo_data_in  output  WIDTH  to the `lifo` data_in port
- lifo_data_out  input  WIDTH  from the `lifo` data_out port
- lifo_empty, lifo_full  input  1  from the `lifo` status ports

## Operation
- **Request classification.** A requester is a push requester when req_push[i]=1. If req_push[i] and req_pop[i] are both 1, push takes precedence; the pop stays pending.
- **Eligibility.**
  - A push is eligible when level<DEPTH.
  - A pop is eligible when level>0.
  - Eligibility uses the internal counter only, never lifo_full or lifo_empty.
- **Arbitration.**
  - Round-robin pointer rr_ptr, 0..NREQ-1.
  - Search eligible requesters starting at rr_ptr, ascending, with wrap-around; the first hit wins.
  - After a grant, rr_ptr <= winner+1 (mod NREQ). With no grant, rr_ptr holds.
  - An ineligible requester is skipped, not blocking. Another requester's eligible operation proceeds in the same cycle.
- **Stack drive.**
  - On a push grant: lifo_push=1, lifo_data_in=req_data slice of the winner.
  - On a pop grant: lifo_pop=1.
  - With no grant: lifo_push=0, lifo_pop=0, lifo_data_in=0.
  - lifo_push and lifo_pop are never high together.
- **Counter.** level increments on a push grant, decrements on a pop grant, and is otherwise unchanged. It never leaves 0..DEPTH.
- **Response.**
  - A pop granted to requester i in cycle N sets rsp_valid[i] for exactly cycle N+1.
  - In cycle N+1, rsp_data = lifo_data_out (the stack presents the popped word the cycle after pop is sampled).
  - When rsp_valid is 0, rsp_data is 0.
- **Consistency check.** In any cycle with no grant in the previous cycle, err sets if (level==0) != lifo_empty or (level==DEPTH) != lifo_full. err clears only on reset.
- **Reset.** Asynchronous assertion immediately forces:
  - rr_ptr=0, level=0, rsp_valid=0, err=0
  - gnt=0, lifo_push=0, lifo_pop=0
  
  A pop response in flight when reset asserts is discarded. Reset mid-operation requires the `lifo` to be reset on the same signal.

## Timing
- Throughput is one operation per cycle, with back-to-back push/pop in any mix.
- Grant latency is 0 cycles: gnt is asserted in the same cycle as the request when the requester is eligible and first in round-robin order.
- Pop-to-data latency is 1 cycle (cycle N grant, cycle N+1 rsp_valid/rsp_data).
- level reflects all grants up to and including the previous edge.
- A pop granted in cycle N+1 at level 1 following a push in cycle N is legal. The counter already reads 1, and data is returned in cycle N+2.
- A requester must hold req_* and req_data stable until gnt, then may change them in the following cycle.
- The bench samples gnt, lifo_push, and lifo_pop just before the rising edge.

## Test plan
- **Reset:** hold rst=0, then release with requests pending. All outputs read 0 and level=0 during reset. Asserting rst=0 mid-stream with level=3 returns level=0, err=0, and rsp_valid=0 immediately.
- **Fill:** requester 0 pushes 0xA001..0xA005 held back-to-back. gnt[0] fires in 4 consecutive cycles and level reaches 4. The 5th push is never granted, and lifo_push=0 while it waits.
- **Drain:** at level 4, requester 2 pops 5 times. rsp_valid[2] arrives one cycle after each gnt with rsp_data 0xA004, 0xA003, 0xA002, 0xA001. The 5th pop stalls at level 0.
- **Round-robin:** at level 0, all four requesters assert push with data 0xB000+i. Grants go 0, 1, 2, 3 in consecutive cycles, then level=4. Popping 4 times returns 0xB003, 0xB002, 0xB001, 0xB000.
- **Skip:** at level 4, requester 0 pushes and requester 1 pops with rr_ptr=0. Requester 1 is granted first and level goes to 3. Requester 0 is granted next cycle and level is back to 4. Same-requester push+pop: push is granted first, then the pop.
- **Error:** force lifo_full=0 while level=4 with no grant pending. err rises next edge and stays 1 until rst=0.

Source files
------------

// File: rtl/lifo_arbiter_if.sv
// Requester-side bundle of the shared-stack arbiter: held push/pop requests in,
// combinational one-hot grant and registered pop responses out.
interface lifo_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
);
   logic [NREQ-1:0]       req_push;
   logic [NREQ-1:0]       req_pop;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;

   modport master (
      output req_push, req_pop, req_data,
      input  gnt, rsp_valid, rsp_data
   );

   modport slave (
      input  req_push, req_pop, req_data,
      output gnt, rsp_valid, rsp_data
   );
endinterface

// File: rtl/lifo_arbiter.sv
// Round-robin sharing of one external lifo among NREQ requesters; grant is 0-cycle,
// pop data returns 1 cycle after grant; ineligible requests simply wait (never block others).
module lifo_arbiter #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int NREQ  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   lifo_arbiter_if.slave              bus,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       err,
   output logic                       lifo_push,
   output logic                       lifo_pop,
   output logic [WIDTH-1:0]           lifo_data_in,
   input  logic [WIDTH-1:0]           lifo_data_out,
   input  logic                       lifo_empty,
   input  logic                       lifo_full
);
   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_nxt;
   logic [PW-1:0]   win;
   logic            found;
   logic            win_push;
   logic            had_gnt;
   logic            push_ok;
   logic            pop_ok;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt_c;
   logic [PW:0]     idx;

   assign push_ok = (level < LW'(DEPTH));
   assign pop_ok  = (level != '0);

   // A requester holding both push and pop is classified as a pusher until served.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = bus.req_push[i] ? push_ok : (bus.req_pop[i] & pop_ok);
      end
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) begin
            idx = idx - (PW+1)'(NREQ);
         end
         if (!found && elig[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   assign win_push = bus.req_push[win];
   assign rr_nxt   = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;

   // Gated by reset so grant and stack strobes drop the instant reset asserts.
   always_comb begin
      gnt_c        = '0;
      lifo_push    = 1'b0;
      lifo_pop     = 1'b0;
      lifo_data_in = '0;
      if (found && rst) begin
         gnt_c[win] = 1'b1;
         if (win_push) begin
            lifo_push    = 1'b1;
            lifo_data_in = bus.req_data[int'(win)*WIDTH +: WIDTH];
         end else begin
            lifo_pop = 1'b1;
         end
      end
   end

   assign bus.gnt      = gnt_c;
   assign bus.rsp_data = (|bus.rsp_valid) ? lifo_data_out : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr        <= '0;
         level         <= '0;
         bus.rsp_valid <= '0;
         err           <= 1'b0;
         had_gnt       <= 1'b0;
      end else begin
         had_gnt       <= found;
         bus.rsp_valid <= (found && !win_push) ? gnt_c : '0;
         if (found) begin
            rr_ptr <= rr_nxt;
            if (win_push) begin
               level <= level + 1'b1;
            end else begin
               level <= level - 1'b1;
            end
         end
         // Stack flags lag a grant by one edge, so only compare after an idle cycle.
         if (!had_gnt && (((level == '0) != lifo_empty) ||
                          ((level == LW'(DEPTH)) != lifo_full))) begin
            err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: behavioural stack stub, queue-based reference model,
// scoreboard of expected pop responses consumed by an independent monitor.
module tb_lifo_arbiter;
   localparam int W = 16;
   localparam int D = 4;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  rq_push = '0;
   logic [N-1:0]  rq_pop = '0;
   logic [N*W-1:0] rq_data = '0;
   logic [2:0]    level;
   logic          err;
   logic          lifo_push, lifo_pop, lifo_empty, lifo_full;
   logic [W-1:0]  lifo_din;
   logic [W-1:0]  lifo_dout;
   logic          force_nfull = 1'b0;

   lifo_arbiter_if #(.NREQ(N), .WIDTH(W)) bus();
   assign bus.req_push = rq_push;
   assign bus.req_pop  = rq_pop;
   assign bus.req_data = rq_data;

   lifo_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
      .clk(clk), .rst(rst), .bus(bus), .level(level), .err(err),
      .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_data_in(lifo_din),
      .lifo_data_out(lifo_dout), .lifo_empty(lifo_empty), .lifo_full(lifo_full)
   );

   always #5 clk = ~clk;

   // Stack stub: presents the popped word the cycle after pop is sampled.
   logic [W-1:0] stk [D];
   int sp;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp        <= 0;
         lifo_dout <= '0;
      end else if (lifo_push && sp < D) begin
         stk[sp] <= lifo_din;
         sp      <= sp + 1;
      end else if (lifo_pop && sp > 0) begin
         lifo_dout <= stk[sp-1];
         sp        <= sp - 1;
      end
   end
   assign lifo_empty = (sp == 0);
   assign lifo_full  = force_nfull ? 1'b0 : (sp == D);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model state
   logic [W-1:0] m_stk[$];
   int           exp_id[$];
   logic [W-1:0] exp_dat[$];
   logic [W-1:0] rx_log[$];
   logic [N-1:0] g_log[$];
   int           m_level = 0;
   int           m_rr = 0;
   int           exp_err = 0;
   int           last_w = -1;
   bit           last_wp = 1'b0;
   int           cnt[N];
   bit           op_push[N];
   logic [W-1:0] nxt[N];
   bit           rand_mode = 1'b0;
   int           stall = 0;

   // Just before the edge: predict the winner from the rules and compare the stack drive.
   task automatic sample();
      int w;
      int i;
      logic [N-1:0] eg;
      logic [W-1:0] ed;
      w  = -1;
      eg = '0;
      ed = '0;
      for (int k = 0; k < N; k++) begin
         i = (m_rr + k) % N;
         if (w < 0 && ((rq_push[i] && m_level < D) || (!rq_push[i] && rq_pop[i] && m_level > 0)))
            w = i;
      end
      if (w >= 0) begin
         eg[w] = 1'b1;
         if (rq_push[w]) ed = rq_data[w*W +: W];
      end
      chk("gnt", bus.gnt, eg);
      chk("lifo_push", lifo_push, (w >= 0) && rq_push[w]);
      chk("lifo_pop", lifo_pop, (w >= 0) && !rq_push[w]);
      chk("lifo_data_in", lifo_din, ed);
      chk("level", level, m_level);
      if (exp_err >= 0) chk("err", err, exp_err);
      if (bus.gnt != 0) g_log.push_back(bus.gnt);
      last_w = w;
      if (w >= 0) begin
         last_wp = rq_push[w];
         if (rq_push[w]) begin
            m_stk.push_back(rq_data[w*W +: W]);
            m_level++;
         end else begin
            exp_id.push_back(w);
            exp_dat.push_back(m_stk.pop_back());
            m_level--;
         end
         m_rr = (w + 1) % N;
      end
   endtask

   task automatic refill();
      int op;
      for (int i = 0; i < N; i++) begin
         if (!rq_push[i] && !rq_pop[i]) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (op_push[i]) begin
                  rq_push[i] = 1'b1;
                  rq_data[i*W +: W] = nxt[i];
                  nxt[i] = nxt[i] + 1'b1;
               end else begin
                  rq_pop[i] = 1'b1;
               end
            end else if (rand_mode && $urandom_range(0, 2) == 0) begin
               op = $urandom_range(0, 2);
               rq_data[i*W +: W] = W'($urandom);
               rq_push[i] = (op != 1);
               rq_pop[i]  = (op != 0);
            end
         end
      end
   endtask

   // Called at a falling edge with inputs settled; returns at the next falling edge.
   task automatic tick();
      #4;
      sample();
      @(negedge clk);
      if (last_w >= 0) begin
         if (last_wp) rq_push[last_w] = 1'b0;
         else         rq_pop[last_w]  = 1'b0;
         stall = 0;
      end else begin
         stall++;
      end
      if (rand_mode && stall > 3) begin
         rq_push = '0;
         rq_pop  = '0;
         stall   = 0;
      end
      refill();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input string nm);
      #2 rst = 1'b0;
      #1;
      chk({nm, "_level"}, level, 0);
      chk({nm, "_err"}, err, 0);
      chk({nm, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({nm, "_gnt"}, bus.gnt, 0);
      chk({nm, "_push_pop"}, {lifo_push, lifo_pop}, 0);
      m_stk.delete(); exp_id.delete(); exp_dat.delete();
      m_level = 0; m_rr = 0; last_w = -1; exp_err = 0;
      rq_push = '0; rq_pop = '0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic check_rx(input string nm, input logic [W-1:0] e0, e1, e2, e3);
      logic [W-1:0] e;
      chk({nm, "_count"}, rx_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
         if (i < rx_log.size()) chk({nm, "_word"}, rx_log[i], e);
      end
   endtask

   task automatic check_g(input string nm, input int n, input logic [N-1:0] a, b, c, d);
      logic [N-1:0] e;
      chk({nm, "_count"}, g_log.size(), n);
      for (int i = 0; i < n; i++) begin
         e = (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : d;
         if (i < g_log.size()) chk({nm, "_order"}, g_log[i], e);
      end
   endtask

   // Monitor: every presented response must match the oldest expected pop.
   always begin
      logic [N-1:0] ev;
      @(posedge clk);
      #1;
      if (rst) begin
         if (bus.rsp_valid != 0) begin
            if (exp_id.size() == 0) begin
               chk("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
               ev = '0;
               ev[exp_id.pop_front()] = 1'b1;
               chk("rsp_valid", bus.rsp_valid, ev);
               chk("rsp_data", bus.rsp_data, exp_dat.pop_front());
               rx_log.push_back(bus.rsp_data);
            end
         end else begin
            chk("rsp_data_idle", bus.rsp_data, 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin cnt[i] = 0; op_push[i] = 1'b0; nxt[i] = '0; end
      rq_push[1] = 1'b1;
      rq_data[1*W +: W] = 16'h1111;
      #2;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_level", level, 0);
      chk("rst_outs", {err, bus.rsp_valid, lifo_push, lifo_pop}, 0);
      chk("rst_data_in", lifo_din, 0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_gnt", bus.gnt, 0);
      chk("rst_hold_rsp", bus.rsp_data, 0);
      cnt[1] = 1; op_push[1] = 1'b0;
      rst = 1'b1;
      run(4);

      // Fill to capacity; the fifth push waits with no stack strobe.
      cnt[0] = 5; op_push[0] = 1'b1; nxt[0] = 16'hA001;
      refill();
      run(6);
      chk("fill_level", level, 4);
      chk("fill_stall_push", lifo_push, 0);
      chk("fill_stall_gnt", bus.gnt, 0);
      rq_push[0] = 1'b0; cnt[0] = 0;

      rx_log.delete();
      cnt[2] = 5; op_push[2] = 1'b0;
      refill();
      run(7);
      check_rx("drain", 16'hA004, 16'hA003, 16'hA002, 16'hA001);
      chk("drain_level", level, 0);
      chk("drain_stall_pop", lifo_pop, 0);
      rq_pop[2] = 1'b0; cnt[2] = 0;

      do_reset("rst_a");
      g_log.delete();
      for (int i = 0; i < N; i++) begin cnt[i] = 1; op_push[i] = 1'b1; nxt[i] = 16'hB000 + W'(i); end
      refill();
      run(5);
      check_g("rr_push", 4, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
      chk("rr_level", level, 4);
      rx_log.delete();
      cnt[0] = 4; op_push[0] = 1'b0;
      refill();
      run(6);
      check_rx("rr_pop", 16'hB003, 16'hB002, 16'hB001, 16'hB000);

      // Full stack, pointer at 0: pusher 0 must be skipped in favour of popper 1.
      cnt[3] = 4; op_push[3] = 1'b1; nxt[3] = 16'hC000;
      refill();
      run(5);
      g_log.delete();
      rq_push[0] = 1'b1; rq_data[0 +: W] = 16'hD000;
      rq_pop[1]  = 1'b1;
      run(3);
      check_g("skip", 2, 4'b0010, 4'b0001, 4'b0000, 4'b0000);
      chk("skip_level", level, 4);
      cnt[3] = 1; op_push[3] = 1'b0;
      refill();
      run(2);
      g_log.delete();
      rq_push[2] = 1'b1; rq_pop[2] = 1'b1; rq_data[2*W +: W] = 16'hD222;
      run(3);
      check_g("same_req", 2, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
      chk("pre_rst_level", level, 3);
      do_reset("rst_mid");

      cnt[1] = 4; op_push[1] = 1'b1; nxt[1] = 16'hF000;
      refill();
      run(6);
      chk("err_pre", err, 0);
      exp_err = -1;
      force_nfull = 1'b1;
      run(2);
      chk("err_rise", err, 1);
      force_nfull = 1'b0;
      exp_err = 1;
      run(3);
      chk("err_sticky", err, 1);
      do_reset("rst_err");

      rand_mode = 1'b1;
      run(800);
      rand_mode = 1'b0;
      rq_push = '0;
      rq_pop  = '0;
      run(3);
      chk("scoreboard_empty", exp_id.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
